// File: rtl/level_meter_pkg.sv
// Shared types for the level-meter path: PCM sample, 15-bit level, follower FSM states.
// Pure declarations; no timing or backpressure of its own.
package level_meter_pkg;
   localparam int PCM_W   = 16;
   localparam int LEVEL_W = 15;

   typedef logic signed [PCM_W-1:0] pcm_t;
   typedef logic [LEVEL_W-1:0]      level_t;

   localparam level_t LEVEL_MAX = 15'd32767;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_UPDATE = 2'd1,
      S_EMIT   = 2'd2
   } state_t;
endpackage

// File: rtl/pcm_abs_saturate.sv
// Rectifies a signed PCM sample to a 15-bit magnitude, clamping -32768 to 32767.
// Combinational, zero latency, no flow control.
module pcm_abs_saturate
   import level_meter_pkg::*;
(
   input  pcm_t   i_pcm,
   output level_t o_mag
);

   logic [PCM_W-1:0] w_neg;
   logic             w_is_min;

   assign w_neg    = PCM_W'(~i_pcm) + PCM_W'(1);
   assign w_is_min = i_pcm[PCM_W-1] && (i_pcm[PCM_W-2:0] == '0);

   always_comb begin
      o_mag = i_pcm[LEVEL_W-1:0];
      if (w_is_min) begin
         o_mag = LEVEL_MAX;
      end else if (i_pcm[PCM_W-1]) begin
         o_mag = w_neg[LEVEL_W-1:0];
      end
   end

endmodule

// File: rtl/pcm_peak_follower.sv
// Peak envelope follower (hold + exponential decay), one level per EMIT_EVERY samples; latest output wins, input never stalls on output.
// Sample every 2 cycles (3 on emit); level valid 2 cycles after acceptance. Hold counter only with PCM_PEAK_FOLLOWER_HOLD_EN.
module pcm_peak_follower
   import level_meter_pkg::*;
#(
   parameter int HOLD_SAMPLES = 1024,
   parameter int DECAY_SHIFT  = 5,
   parameter int EMIT_EVERY   = 16
)(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_valid,
   output logic        i_ready,
   input  logic [15:0] i_pcm,
   output logic        o_valid,
   input  logic        o_ready,
   output logic [14:0] o_level
);

   localparam int EMIT_W = (EMIT_EVERY > 1) ? $clog2(EMIT_EVERY) : 1;

   state_t            r_state;
   state_t            w_state_nxt;
   level_t            r_mag;
   level_t            r_peak;
   level_t            r_o_level;
   logic              r_o_valid;
   logic [EMIT_W-1:0] r_emit_cnt;

   level_t            w_mag;
   level_t            w_step;
   level_t            w_peak_dec;
   logic              w_new_peak;
   logic              w_emit_due;
   logic              w_hold_zero;

   pcm_abs_saturate u_abs (
      .i_pcm (pcm_t'(i_pcm)),
      .o_mag (w_mag)
   );

   assign w_new_peak = (r_mag >= r_peak);
   assign w_emit_due = (r_emit_cnt == EMIT_W'(EMIT_EVERY - 1));
   assign w_step     = ((r_peak >> DECAY_SHIFT) == '0) ? level_t'(1) : (r_peak >> DECAY_SHIFT);
   // step never exceeds a nonzero peak, so the subtraction cannot wrap
   assign w_peak_dec = r_peak - w_step;

`ifdef PCM_PEAK_FOLLOWER_HOLD_EN
   localparam int HOLD_W = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;
   logic [HOLD_W-1:0] r_hold_cnt;

   assign w_hold_zero = (r_hold_cnt == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hold_cnt <= '0;
      end else if (r_state == S_UPDATE) begin
         if (w_new_peak) begin
            r_hold_cnt <= HOLD_W'(HOLD_SAMPLES);
         end else if (!w_hold_zero) begin
            r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
         end
      end
   end
`else
   assign w_hold_zero = 1'b1;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      i_ready     = 1'b0;
      case (r_state)
         S_IDLE: begin
            i_ready = 1'b1;
            if (i_valid) begin
               w_state_nxt = S_UPDATE;
            end
         end
         S_UPDATE: w_state_nxt = w_emit_due ? S_EMIT : S_IDLE;
         S_EMIT:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mag      <= '0;
         r_peak     <= '0;
         r_emit_cnt <= '0;
         r_o_level  <= '0;
         r_o_valid  <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && i_valid) begin
            r_mag <= w_mag;
         end

         if (r_state == S_UPDATE) begin
            if (w_new_peak) begin
               r_peak <= r_mag;
            end else if (w_hold_zero && (r_peak != '0)) begin
               r_peak <= w_peak_dec;
            end
            if (!w_emit_due) begin
               r_emit_cnt <= r_emit_cnt + EMIT_W'(1);
            end
         end

         // a fresh emit overrides a same-cycle downstream accept
         if (r_state == S_EMIT) begin
            r_emit_cnt <= '0;
            r_o_level  <= r_peak;
            r_o_valid  <= 1'b1;
         end else if (r_o_valid && o_ready) begin
            r_o_valid  <= 1'b0;
         end
      end
   end

   assign o_valid = r_o_valid;
   assign o_level = r_o_level;

endmodule
